// File: rtl/adder_arbiter_if.sv
// Request/response bundle for adder_arbiter: per-requester beats in, one registered result out.
// slave = arbiter side, master = client/consumer side.
interface adder_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_x;
  logic [NUM_REQ*WIDTH-1:0] req_y;
  logic [NUM_REQ-1:0]       req_carry_in;
  logic [NUM_REQ-1:0]       req_chain;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_carry_out;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_last;

  modport slave (
    input  req_valid, req_x, req_y, req_carry_in, req_chain, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry_out, rsp_id, rsp_last
  );

  modport master (
    output req_valid, req_x, req_y, req_carry_in, req_chain, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry_out, rsp_id, rsp_last
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin shared add-with-carry with locked multi-beat chains; result registered, 1-cycle latency.
// Backpressure: req_ready drops whenever the result register is full and rsp_ready is low.
module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input logic            clk,
  input logic            rst_n,
  adder_arbiter_if.slave bus
);

  typedef enum logic [0:0] {ARB, LOCKED} state_t;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic [ID_W-1:0]  id;
    logic             last;
  } rsp_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic            chain_carry_q, chain_carry_d;
  rsp_t            rsp_q;

  logic            can_accept;
  logic            found;
  logic [ID_W-1:0] grant;
  logic [ID_W-1:0] sel;
  logic            cin;
  logic            accept;
  logic [WIDTH:0]  add_res;
  int              scan_idx;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
    return (i == ID_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  assign can_accept = !rsp_q.vld || bus.rsp_ready;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grant    = rr_ptr_q;
    scan_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (!found && bus.req_valid[scan_idx]) begin
        found = 1'b1;
        grant = ID_W'(scan_idx);
      end
    end
  end

  // While locked, the owner's own carry_in is ignored in favour of the chained carry.
  always_comb begin
    sel = grant;
    cin = bus.req_carry_in[grant];
    if (state_q == LOCKED) begin
      sel = owner_q;
      cin = chain_carry_q;
    end
  end

  assign add_res = (WIDTH+1)'(bus.req_x[int'(sel)*WIDTH +: WIDTH])
                 + (WIDTH+1)'(bus.req_y[int'(sel)*WIDTH +: WIDTH])
                 + (WIDTH+1)'(cin);

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    chain_carry_d = chain_carry_q;
    accept        = 1'b0;
    bus.req_ready = '0;
    case (state_q)
      ARB: begin
        accept = found && can_accept;
        if (accept) begin
          if (bus.req_chain[sel]) begin
            state_d       = LOCKED;
            owner_d       = sel;
            chain_carry_d = add_res[WIDTH];
          end else begin
            rr_ptr_d = wrap_inc(sel);
          end
        end
      end
      LOCKED: begin
        accept = bus.req_valid[owner_q] && can_accept;
        if (accept) begin
          chain_carry_d = add_res[WIDTH];
          if (!bus.req_chain[owner_q]) begin
            state_d  = ARB;
            rr_ptr_d = wrap_inc(owner_q);
          end
        end
      end
      default: state_d = ARB;
    endcase
    bus.req_ready[sel] = accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      chain_carry_q <= 1'b0;
      rsp_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      chain_carry_q <= chain_carry_d;
      if (accept) begin
        rsp_q.vld   <= 1'b1;
        rsp_q.sum   <= add_res[WIDTH-1:0];
        rsp_q.carry <= add_res[WIDTH];
        rsp_q.id    <= sel;
        rsp_q.last  <= !bus.req_chain[sel];
      end else if (bus.rsp_ready) begin
        rsp_q.vld <= 1'b0;
      end
    end
  end

  assign bus.rsp_valid     = rsp_q.vld;
  assign bus.rsp_sum       = rsp_q.sum;
  assign bus.rsp_carry_out = rsp_q.carry;
  assign bus.rsp_id        = rsp_q.id;
  assign bus.rsp_last      = rsp_q.last;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: single beat, overflow, round-robin, chain lock, stall, async reset.
module tb_adder_arbiter;
  localparam int N = 4;
  localparam int W = 8;
  localparam int IW = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  adder_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) bus ();

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic ch, input logic v);
    bus.req_x[i*W +: W]   = x;
    bus.req_y[i*W +: W]   = y;
    bus.req_carry_in[i]   = ci;
    bus.req_chain[i]      = ch;
    bus.req_valid[i]      = v;
  endtask

  task automatic chk_rsp(input string tag, input logic [7:0] sum, input logic co,
                         input logic [1:0] id, input logic last);
    chk({tag, ".valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, ".sum"},   32'(bus.rsp_sum), 32'(sum));
    chk({tag, ".carry"}, 32'(bus.rsp_carry_out), 32'(co));
    chk({tag, ".id"},    32'(bus.rsp_id), 32'(id));
    chk({tag, ".last"},  32'(bus.rsp_last), 32'(last));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.req_valid    = '0;
    bus.req_x        = '0;
    bus.req_y        = '0;
    bus.req_carry_in = '0;
    bus.req_chain    = '0;
    bus.rsp_ready    = 1'b1;

    #2;
    chk("rst.valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst.sum",   32'(bus.rsp_sum), 32'd0);
    chk("rst.carry", 32'(bus.rsp_carry_out), 32'd0);
    chk("rst.id",    32'(bus.rsp_id), 32'd0);
    chk("rst.last",  32'(bus.rsp_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // single beat, requester 0
    set_req(0, 8'h12, 8'h34, 1'b1, 1'b0, 1'b1);
    #1 chk("single.ready", 32'(bus.req_ready), 32'b0001);
    tick();
    set_req(0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_rsp("single", 8'h47, 1'b0, 2'd0, 1'b1);

    // overflow on requester 1 (rr_ptr now 1)
    set_req(1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    #1 chk("ovf.ready", 32'(bus.req_ready), 32'b0010);
    tick();
    set_req(1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_rsp("ovf", 8'h00, 1'b1, 2'd1, 1'b1);
    tick();
    chk("drain.valid", 32'(bus.rsp_valid), 32'd0);

    // requester 3 beat brings rr_ptr back to 0: 0x80+0x80+1 = 0x101
    set_req(3, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
    #1 chk("r3.ready", 32'(bus.req_ready), 32'b1000);
    tick();
    set_req(3, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    chk_rsp("r3", 8'h01, 1'b1, 2'd3, 1'b1);

    // round robin: all valid, requester i adds i*0x10 + 1
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 16), 8'h01, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1 chk("rr.ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      chk("rr.valid", 32'(bus.rsp_valid), 32'd1);
      chk("rr.id",    32'(bus.rsp_id), 32'(k % 4));
      chk("rr.sum",   32'(bus.rsp_sum), 32'((k % 4) * 16 + 1));
    end
    bus.req_valid = '0;
    tick();
    chk("rr.drain", 32'(bus.rsp_valid), 32'd0);

    // chain on requester 2 (rr_ptr now 2) with requester 1 competing
    set_req(2, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
    set_req(1, 8'h05, 8'h05, 1'b0, 1'b0, 1'b1);
    #1 chk("chainA.ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_rsp("chainA", 8'h00, 1'b1, 2'd2, 1'b0);
    set_req(2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1 chk("gap.ready", 32'(bus.req_ready), 32'd0);
      tick();
      chk("gap.valid", 32'(bus.rsp_valid), 32'd0);
    end
    set_req(2, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 chk("chainB.ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_rsp("chainB", 8'h01, 1'b0, 2'd2, 1'b1);
    bus.req_valid[2] = 1'b0;
    #1 chk("post.ready", 32'(bus.req_ready), 32'b0010);
    tick();
    chk_rsp("post", 8'h0A, 1'b0, 2'd1, 1'b1);
    bus.req_valid[1] = 1'b0;

    // backpressure: hold result of requester 1 for 5 cycles
    bus.rsp_ready = 1'b0;
    set_req(0, 8'h20, 8'h22, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #1 chk("stall.ready", 32'(bus.req_ready), 32'd0);
      chk_rsp("stall", 8'h0A, 1'b0, 2'd1, 1'b1);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1 chk("unstall.ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_rsp("unstall", 8'h42, 1'b0, 2'd0, 1'b1);
    bus.req_valid[0] = 1'b0;

    // lock on requester 2 (rr_ptr now 1), hold result, then reset asynchronously
    set_req(2, 8'h01, 8'h01, 1'b0, 1'b1, 1'b1);
    #1 chk("lock.ready", 32'(bus.req_ready), 32'b0100);
    tick();
    bus.rsp_ready = 1'b0;
    bus.req_valid[2] = 1'b0;
    chk_rsp("lock", 8'h02, 1'b0, 2'd2, 1'b0);
    #1 rst_n = 1'b0;
    #1 chk("arst.valid", 32'(bus.rsp_valid), 32'd0);
    set_req(0, 8'h03, 8'h04, 1'b0, 1'b0, 1'b1);
    set_req(2, 8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel.ready", 32'(bus.req_ready), 32'b0001);
    tick();
    chk_rsp("rel", 8'h07, 1'b0, 2'd0, 1'b1);
    bus.req_valid[0] = 1'b0;
    #1 chk("rel2.ready", 32'(bus.req_ready), 32'b0100);
    tick();
    chk_rsp("rel2", 8'h31, 1'b0, 2'd2, 1'b1);
    bus.req_valid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one WIDTH-bit add-with-carry datapath (sum = x + y + carry_in, carry out of the top bit) among NUM_REQ requesters.
- Arbitrates round-robin and registers one result with a valid/ready response.
- Supports locked multi-beat "chain" transactions: the carry from one beat feeds the next, so a requester can add operands wider than WIDTH.
- Sits between compute clients and the shared adder. It is the only path to the adder.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- WIDTH, 8, operand/sum width in bits.
- ID_W, $clog2(NUM_REQ) (min 1), width of rsp_id.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_x  in  NUM_REQ*WIDTH  operand x, requester i at [i*WIDTH +: WIDTH].
- req_y  in  NUM_REQ*WIDTH  operand y, same packing.
- req_carry_in  in  NUM_REQ  carry in; used only on the first beat of a chain or a single beat.
- req_chain  in  NUM_REQ  1 = more beats follow for this requester.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  registered sum.
- rsp_carry_out  out  1  registered carry out.
- rsp_id  out  ID_W  index of the requester that produced the result.
- rsp_last  out  1  1 = beat was the final (non-chain) beat.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_sum=0, rsp_carry_out=0, rsp_id=0, rsp_last=0.
  - state=ARB, rr_ptr=0, owner=0, chain_carry=0.
  - Any in-progress lock is abandoned; no partial result is held.
- Accept condition: can_accept = !rsp_valid || rsp_ready. The output slot frees and refills in the same cycle, giving full throughput.
- State ARB:
  - The eligible set is all i with req_valid[i].
  - grant = first eligible index scanning rr_ptr, rr_ptr+1, … with wrap modulo NUM_REQ.
  - req_ready[grant] = can_accept. All other req_ready bits are 0.
  - Operands for the accepted beat: x, y and req_carry_in of the granted requester.
  - If the accepted beat has req_chain=1: go to LOCKED, owner=grant, chain_carry=computed carry out. rr_ptr is unchanged.
  - If the accepted beat has req_chain=0: rr_ptr=(grant+1) mod NUM_REQ.
- State LOCKED:
  - Only the owner is eligible. req_ready[owner] = req_valid[owner] && can_accept.
  - The adder carry_in is chain_carry; req_carry_in[owner] is ignored.
  - On an accepted beat, chain_carry = new carry out.
  - If that beat has req_chain=0: go to ARB, rr_ptr=(owner+1) mod NUM_REQ.
  - If the owner deasserts req_valid, stay LOCKED indefinitely. There is no timeout, and other requesters are starved by design.
- Result register: on an accepted beat, the next edge loads rsp_valid=1, rsp_sum, rsp_carry_out, rsp_id=grant, rsp_last=!req_chain.
  - Otherwise, if rsp_ready=1, then rsp_valid=0.
  - Latency from accept to rsp_valid is 1 cycle.
- Stall: while rsp_valid && !rsp_ready, all req_ready=0 and every rsp_* output is held stable.
- Arithmetic: {carry_out, sum} = x + y + cin, evaluated at WIDTH+1 bits. There is no saturation, and the top bit is never dropped.
- Combinational paths:
  - req_ready may depend combinationally on req_valid and rsp_ready.
  - Requesters must not make req_valid depend on req_ready.
  - req_x, req_y, req_carry_in and req_chain must be stable while req_valid=1 and not yet accepted.
- NUM_REQ=1: arbitration is trivial and rr_ptr stays 0; chaining still works.

Test Plan:
- Single beat: req0 x=0x12, y=0x34, cin=1, chain=0, rsp_ready=1 → req_ready[0]=1 that cycle; next cycle rsp_valid=1, sum=0x47, carry=0, id=0, last=1.
- Overflow: req1 x=0xFF, y=0x01, cin=0 → sum=0x00, carry_out=1, id=1.
- Round-robin: all 4 valid every cycle, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 on consecutive cycles, one result per cycle.
- Chain:
  - Stimulus: req2 beat A (x=0xFF, y=0x01, cin=0, chain=1), then beat B (x=0x00, y=0x00, cin=0, chain=0). req1 is valid throughout and req2 has a 2-cycle valid gap between beats.
  - Required response: rsp A sum=0x00, carry=1; req1 is never granted during the gap; rsp B sum=0x01, carry=0, last=1. The next grant goes to req3 if valid, else req1.
- Backpressure: rsp_valid=1, rsp_ready=0 for 5 cycles with req0 valid → all req_ready=0 and rsp_* unchanged. When rsp_ready rises, req0 is accepted that same cycle and the new result appears next cycle.
- Reset mid-lock: rst_n low while LOCKED on req2 with rsp_valid=1 → rsp_valid=0 immediately, without waiting for a clock edge. After release with req0 and req2 valid, req0 is granted first (rr_ptr=0, ARB).
